char_column_display: RTL and testbench

//  Sink end of the character stream interface (write / char / column beats, 4 beats per char).

---
 rtl/char_column_display_if.sv | 9 +
 rtl/char_column_display.sv | 190 +++++++++++++++++++
 tb/tb_char_column_display.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/char_column_display_if.sv
// Character stream interface: one glyph-column beat per cycle while write is high.
interface char_column_display_if;
  logic       write;
  logic [7:0] char_in;
  logic [1:0] column;

  modport master (output write, char_in, column);
  modport slave  (input  write, char_in, column);
endinterface

// File: rtl/char_column_display.sv
// Character stream sink: font ROM -> column frame buffer -> multiplexed 8-row LED scan-out.
// Optional CHAR_DISPLAY_SCROLL_EN scrolls the text left one column per full frame.
module char_column_display #(
  parameter int NUM_COLS = 32,
  parameter int SCAN_DIV = 1000,
  parameter int COL_W    = $clog2(NUM_COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  char_column_display_if.slave stream,
  output logic [7:0]           led_row,
  output logic [COL_W-1:0]     led_col,
  output logic                 frame_valid,
  output logic                 msg_done,
  output logic [COL_W-2:0]     char_count,
  output logic                 proto_err
);

  localparam int CNT_W  = COL_W - 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Font word: [31:24] = glyph column 0 ... [7:0] = glyph column 3; bit0 = top row.
  function automatic logic [31:0] glyph_word(input logic [7:0] code);
    logic [31:0] w;
    w = 32'h0;
    case (code)
      8'h20: w = 32'h00000000;  8'h21: w = 32'h005F0000;
      8'h22: w = 32'h00070007;  8'h23: w = 32'h147F147F;
      8'h24: w = 32'h242A7F12;  8'h25: w = 32'h23086462;
      8'h26: w = 32'h36495620;  8'h27: w = 32'h00070000;
      8'h28: w = 32'h001C2241;  8'h29: w = 32'h41221C00;
      8'h2A: w = 32'h2A1C1C2A;  8'h2B: w = 32'h08083E08;
      8'h2C: w = 32'h00503000;  8'h2D: w = 32'h08080808;
      8'h2E: w = 32'h00606000;  8'h2F: w = 32'h60180603;
      8'h30: w = 32'h3E41413E;  8'h31: w = 32'h00427F40;
      8'h32: w = 32'h62514946;  8'h33: w = 32'h22494936;
      8'h34: w = 32'h18147F10;  8'h35: w = 32'h27454539;
      8'h36: w = 32'h3E494930;  8'h37: w = 32'h01710907;
      8'h38: w = 32'h36494936;  8'h39: w = 32'h0649493E;
      8'h3A: w = 32'h00363600;  8'h3B: w = 32'h00563600;
      8'h3C: w = 32'h08142241;  8'h3D: w = 32'h14141414;
      8'h3E: w = 32'h41221408;  8'h3F: w = 32'h02510906;
      8'h40: w = 32'h3E415D4E;  8'h41: w = 32'h7E09097E;
      8'h42: w = 32'h7F494936;  8'h43: w = 32'h3E414122;
      8'h44: w = 32'h7F41413E;  8'h45: w = 32'h7F494941;
      8'h46: w = 32'h7F090901;  8'h47: w = 32'h3E41497A;
      8'h48: w = 32'h7F08087F;  8'h49: w = 32'h00417F41;
      8'h4A: w = 32'h2040413F;  8'h4B: w = 32'h7F081463;
      8'h4C: w = 32'h7F404040;  8'h4D: w = 32'h7F02027F;
      8'h4E: w = 32'h7F04087F;  8'h4F: w = 32'h3E41413E;
      8'h50: w = 32'h7F090906;  8'h51: w = 32'h3E41615E;
      8'h52: w = 32'h7F091966;  8'h53: w = 32'h26494932;
      8'h54: w = 32'h017F0101;  8'h55: w = 32'h3F40403F;
      8'h56: w = 32'h1F60601F;  8'h57: w = 32'h7F20207F;
      8'h58: w = 32'h63141463;  8'h59: w = 32'h03047803;
      8'h5A: w = 32'h61594543;
      default: w = 32'h00000000;
    endcase
    return w;
  endfunction

  logic             write_q;
  logic [COL_W-1:0] wr_ptr;
  logic             buf_full;
  logic [1:0]       exp_col;
  logic [7:0]       fb [NUM_COLS];

  logic             wr_en_q;
  logic [COL_W-1:0] wr_addr_q;
  logic [7:0]       wr_data_q;

  logic [SCAN_W-1:0] scan_cnt;
  logic [COL_W-1:0]  scroll_off;

  logic             msg_start, msg_end, accept, drop, seq_err;
  logic [COL_W-1:0] ptr_eff;
  logic             full_eff;
  logic [1:0]       exp_eff;
  logic [CNT_W-1:0] cnt_eff;
  logic [31:0]      word;
  logic [7:0]       glyph;

  // A start beat is judged against freshly cleared message state.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    msg_start = stream.write & ~write_q;
    msg_end   = ~stream.write & write_q;
    ptr_eff   = msg_start ? '0   : wr_ptr;
    full_eff  = msg_start ? 1'b0 : buf_full;
    exp_eff   = msg_start ? 2'd0 : exp_col;
    cnt_eff   = msg_start ? '0   : char_count;
    accept    = stream.write & ~full_eff;
    drop      = stream.write & full_eff;
    seq_err   = accept & (stream.column != exp_eff);
    word      = glyph_word(stream.char_in);
    glyph     = 8'h00;
    case (stream.column)
      2'd0: glyph = word[31:24];
      2'd1: glyph = word[23:16];
      2'd2: glyph = word[15:8];
      2'd3: glyph = word[7:0];
      default: glyph = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q     <= 1'b0;
      wr_ptr      <= '0;
      buf_full    <= 1'b0;
      exp_col     <= 2'd0;
      char_count  <= '0;
      proto_err   <= 1'b0;
      msg_done    <= 1'b0;
      frame_valid <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
    end else begin
      write_q    <= stream.write;
      msg_done   <= msg_end;
      if (msg_end) frame_valid <= 1'b1;
      if (seq_err || drop) proto_err <= 1'b1;

      wr_en_q    <= accept;
      wr_addr_q  <= ptr_eff;
      wr_data_q  <= glyph;

      wr_ptr     <= ptr_eff;
      buf_full   <= full_eff;
      exp_col    <= exp_eff;
      char_count <= cnt_eff;
      if (accept) begin
        exp_col <= stream.column + 2'd1;
        // The last slot is marked full instead of wrapping the pointer.
        if (ptr_eff == COL_W'(NUM_COLS - 1)) buf_full <= 1'b1;
        else                                 wr_ptr   <= ptr_eff + COL_W'(1);
        if (stream.column == 2'd3 && cnt_eff != '1)
          char_count <= cnt_eff + CNT_W'(1);
      end
    end
  end

  // NOTE: the frame buffer must read as blank after reset, so it is a reset
  // flop array rather than an inferred RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COLS; i++) fb[i] <= 8'h00;
    end else if (wr_en_q) begin
      fb[wr_addr_q] <= wr_data_q;
    end
  end

  logic             scan_wrap;
  logic [COL_W-1:0] rd_addr;

  always_comb begin
    scan_wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    rd_addr   = led_col + scroll_off;
  end

  // led_row follows led_col by one cycle; a same-cycle write is seen next scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      led_col  <= '0;
      led_row  <= 8'h00;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SCAN_W'(1);
      if (scan_wrap) led_col <= led_col + COL_W'(1);
      led_row  <= frame_valid ? fb[rd_addr] : 8'h00;
    end
  end

`ifdef CHAR_DISPLAY_SCROLL_EN
  logic frame_wrap;
  assign frame_wrap = scan_wrap & (led_col == COL_W'(NUM_COLS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             scroll_off <= '0;
    else if (msg_start)  scroll_off <= '0;
    else if (frame_wrap) scroll_off <= scroll_off + COL_W'(1);
  end
`else
  assign scroll_off = '0;
`endif

endmodule

// File: tb/tb_char_column_display.sv
// Self-checking bench for char_column_display: table vectors, hand corner cases,
// and random messages against a message-level reference model.
module tb_char_column_display;
  localparam int N  = 32;
  localparam int SD = 4;
  localparam int F  = N * SD;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  char_column_display_if sif();
  logic [7:0]    led_row;
  logic [CW-1:0] led_col;
  logic          frame_valid, msg_done, proto_err;
  logic [CW-2:0] char_count;

  char_column_display #(.NUM_COLS(N), .SCAN_DIV(SD), .COL_W(CW)) dut (
    .clk(clk), .rst(rst), .stream(sif),
    .led_row(led_row), .led_col(led_col), .frame_valid(frame_valid),
    .msg_done(msg_done), .char_count(char_count), .proto_err(proto_err)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;   // clock edges since reset released
  always @(posedge clk or posedge rst) if (rst) cyc <= 0; else cyc <= cyc + 1;

  logic [7:0] exp_fb [N];
  logic       m_err;
  int         m_cnt;
  bit         exp_fv;
  int         s_edge;

  typedef struct {
    bit         rst_first;
    logic [7:0] ch;
    logic [1:0] col;
    logic [7:0] glyph;
    logic       err;
    int         cnt;
    bit         last;
  } vec_t;
  vec_t vecs[$];

  logic [7:0] b_ch  [64];
  logic [1:0] b_col [64];
  logic [7:0] pool  [8] = '{8'h20, 8'h49, 8'h4D, 8'h00, 8'h7F, 8'h5B, 8'hC1, 8'h1F};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic add(input bit r, input logic [7:0] ch, input logic [1:0] col,
                     input logic [7:0] g, input logic e, input int c, input bit l);
    vec_t v;
    v = '{r, ch, col, g, e, c, l};
    vecs.push_back(v);
  endtask

  function automatic logic [7:0] ref_glyph(input logic [7:0] ch, input int col);
    logic [31:0] w;
    case (ch)
      8'h49:   w = 32'h00417F41;   // 'I'
      8'h4D:   w = 32'h7F02027F;   // 'M'
      default: w = 32'h0;          // ' ' and codes outside 0x20..0x5A
    endcase
    return w[31-8*col -: 8];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) exp_fb[i] = 8'h00;
    m_err = 1'b0; m_cnt = 0; exp_fv = 1'b0; s_edge = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_led_row"}, led_row, 0);
    check({tag, "_led_col"}, led_col, 0);
    check({tag, "_frame_valid"}, frame_valid, 0);
    check({tag, "_msg_done"}, msg_done, 0);
    check({tag, "_char_count"}, char_count, 0);
    check({tag, "_proto_err"}, proto_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sif.write = 1'b0;
    rst = 1'b1;
    #1 check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic drive_beat(input logic [7:0] ch, input logic [1:0] col);
    sif.write = 1'b1; sif.char_in = ch; sif.column = col;
    @(negedge clk);
  endtask

  task automatic end_msg();
    sif.write = 1'b0;
    @(negedge clk);
    check("msg_done_pulse", msg_done, 1);
    check("frame_valid_set", frame_valid, 1);
    check("final_char_count", char_count, m_cnt);
    check("final_proto_err", proto_err, m_err);
    exp_fv = 1'b1;
    @(negedge clk);
    check("msg_done_single", msg_done, 0);
  endtask

  // Scan position and scroll derived from the edge count since reset.
  task automatic check_frame();
    int k, kp, col_p, sc;
    logic [7:0] row;
    repeat (F + SD) begin
      @(negedge clk);
      k  = cyc;
      kp = k - 1;
      check("scan_led_col", led_col, (k / SD) % N);
      col_p = (kp / SD) % N;
`ifdef CHAR_DISPLAY_SCROLL_EN
      sc = ((kp / F) - (s_edge / F)) % N;
`else
      sc = 0;
`endif
      row = exp_fv ? exp_fb[(col_p + sc) % N] : 8'h00;
      check("scan_led_row", led_row, row);
    end
  endtask

  // Spec-level model of a whole message: sequential slots, no wrap, sticky error.
  task automatic send_model(input int n);
    int ptr, ec;
    bit full;
    ptr = 0; ec = 0; full = 0; m_cnt = 0;
    s_edge = cyc + 1;
    for (int i = 0; i < n; i++) begin
      drive_beat(b_ch[i], b_col[i]);
      if (full) m_err = 1'b1;
      else begin
        if (int'(b_col[i]) != ec) m_err = 1'b1;
        ec = (int'(b_col[i]) + 1) % 4;
        if (b_col[i] == 2'd3 && m_cnt < 15) m_cnt++;
        exp_fb[ptr] = ref_glyph(b_ch[i], int'(b_col[i]));
        if (ptr == N - 1) full = 1; else ptr++;
      end
      check("beat_proto_err", proto_err, m_err);
      check("beat_char_count", char_count, m_cnt);
    end
    end_msg();
    check_frame();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bi;
    // "MI" in order
    add(1, 8'h4D, 0, 8'h7F, 0, 0, 0); add(0, 8'h4D, 1, 8'h02, 0, 0, 0);
    add(0, 8'h4D, 2, 8'h02, 0, 0, 0); add(0, 8'h4D, 3, 8'h7F, 0, 1, 0);
    add(0, 8'h49, 0, 8'h00, 0, 1, 0); add(0, 8'h49, 1, 8'h41, 0, 1, 0);
    add(0, 8'h49, 2, 8'h7F, 0, 1, 0); add(0, 8'h49, 3, 8'h41, 0, 2, 1);
    // column skip 0,1,3,0: error on the third beat, all stored
    add(1, 8'h4D, 0, 8'h7F, 0, 0, 0); add(0, 8'h4D, 1, 8'h02, 0, 0, 0);
    add(0, 8'h4D, 3, 8'h7F, 1, 1, 0); add(0, 8'h4D, 0, 8'h7F, 1, 1, 1);
    // codes just outside the table range and space are blank
    add(1, 8'h1F, 0, 8'h00, 0, 0, 0); add(0, 8'h1F, 1, 8'h00, 0, 0, 0);
    add(0, 8'h1F, 2, 8'h00, 0, 0, 0); add(0, 8'h1F, 3, 8'h00, 0, 1, 0);
    add(0, 8'h20, 0, 8'h00, 0, 1, 0); add(0, 8'h20, 1, 8'h00, 0, 1, 0);
    add(0, 8'h20, 2, 8'h00, 0, 1, 0); add(0, 8'h20, 3, 8'h00, 0, 2, 0);
    add(0, 8'h5B, 0, 8'h00, 0, 2, 0); add(0, 8'h5B, 1, 8'h00, 0, 2, 0);
    add(0, 8'h5B, 2, 8'h00, 0, 2, 0); add(0, 8'h5B, 3, 8'h00, 0, 3, 1);

    sif.write = 1'b0; sif.char_in = 8'h00; sif.column = 2'd0;
    clear_model();
    bi = 0;
    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      if (bi == 0) s_edge = cyc + 1;
      drive_beat(vecs[i].ch, vecs[i].col);
      if (bi < N) exp_fb[bi] = vecs[i].glyph;
      bi++;
      check("vec_proto_err", proto_err, vecs[i].err);
      check("vec_char_count", char_count, vecs[i].cnt);
      m_err = vecs[i].err;
      m_cnt = vecs[i].cnt;
      if (vecs[i].last) begin
        end_msg();
        check_frame();
        bi = 0;
      end
    end

    // Reset in the middle of a message: outputs clear at once, no msg_done.
    drive_beat(8'h4D, 0); drive_beat(8'h4D, 1); drive_beat(8'h4D, 3);
    rst = 1'b1;
    #1 check_zero("midreset");
    sif.write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    repeat (3) begin
      @(negedge clk);
      check("midreset_no_done", msg_done, 0);
      check("midreset_fv_low", frame_valid, 0);
    end
    check_frame();

    // Overflow: NUM_COLS + 1 beats, last dropped without wrapping.
    do_reset();
    for (int i = 0; i < N; i++) begin
      b_ch[i]  = ((i / 4) % 2 == 0) ? 8'h4D : 8'h49;
      b_col[i] = 2'(i % 4);
    end
    b_ch[N] = 8'h49; b_col[N] = 2'd0;
    send_model(N + 1);

    // Random messages, mostly in-sequence columns, with and without reset between.
    for (int r = 0; r < 8; r++) begin
      int n, ec;
      if (r == 0 || $urandom_range(1, 0) == 1) do_reset();
      n  = $urandom_range(36, 1);
      ec = 0;
      for (int i = 0; i < n; i++) begin
        b_ch[i]  = pool[$urandom_range(7, 0)];
        b_col[i] = ($urandom_range(9, 0) < 8) ? 2'(ec) : 2'($urandom_range(3, 0));
        ec = (int'(b_col[i]) + 1) % 4;
      end
      send_model(n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
